// File: rtl/sim_pkg.sv
// Shared types and default sizing for the particle simulator: scheduler
// phases, scheduler states, and the particle index width/count used by the
// update buffer and the compute pipelines.
package sim_pkg;

  localparam int ADDR_WIDTH_DEF     = 7;
  localparam int PARTICLE_COUNT_DEF = 128;

  // Phase reported to the renderer and top level.
  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_DENSITY = 2'd1,
    PH_UPDATE  = 2'd2,
    PH_SWAP    = 2'd3
  } phase_t;

  // Frame sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEN_ISSUE,
    ST_DEN_DRAIN,
    ST_UPD_ISSUE,
    ST_UPD_DRAIN,
    ST_SWAP_START,
    ST_SWAP_ARM,
    ST_SWAP_WAIT,
    ST_DONE
  } sched_state_t;

  // Map a sequencer state onto the externally visible phase. DONE reports
  // IDLE because the frame is already complete in that cycle.
  function automatic phase_t phase_of(sched_state_t s);
    phase_t p;
    case (s)
      ST_DEN_ISSUE, ST_DEN_DRAIN:              p = PH_DENSITY;
      ST_UPD_ISSUE, ST_UPD_DRAIN:              p = PH_UPDATE;
      ST_SWAP_START, ST_SWAP_ARM, ST_SWAP_WAIT: p = PH_SWAP;
      default:                                 p = PH_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/index_issuer.sv
// Presents particle indices 0..count-1 on a valid/ready handshake. A start
// pulse rewinds to index 0 and raises valid on the following cycle; the
// index advances only on an accepted transfer and holds while stalled.
module index_issuer
  import sim_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic                  valid,
  input  logic                  ready,
  output logic                  last_accepted
);

  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] last_idx;

  assign last_idx      = count - ONE;
  // The final index of the pass is being transferred this cycle.
  assign last_accepted = valid && ready && ({1'b0, idx} == last_idx);

  // Index/valid register: rewind on start, advance on accept, stop after last.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples the values present before the clock edge.
    if (rst) begin
      idx   <= '0;
      valid <= 1'b0;
    end else if (start) begin
      idx   <= '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (last_accepted) begin
        valid <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_step_scheduler.sv
// Frame-level sequencer: density pass, update pass, then buffer swap. One
// index issuer is shared by both passes; a guard counter keeps the drain
// from trusting pipe_busy_in until the last issued index has entered the
// pipeline. Every top-level output comes straight from a register.
module sim_step_scheduler
  import sim_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int PARTICLE_COUNT  = PARTICLE_COUNT_DEF,
  parameter int DRAIN_GUARD     = 2,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       run_in,
  input  logic                       step_in,
  output logic [ADDR_WIDTH-1:0]      idx_out,
  output logic                       idx_valid_out,
  input  logic                       idx_ready_in,
  input  logic                       pipe_busy_in,
  output logic [1:0]                 phase_out,
  output logic                       swap_activate_out,
  input  logic                       swap_done_in,
  output logic                       frame_done_out,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count_out,
  output logic                       busy_out
);

  localparam int                    GUARD_W    = $clog2(DRAIN_GUARD + 1);
  localparam logic [GUARD_W-1:0]    GUARD_LOAD = GUARD_W'(DRAIN_GUARD);
  localparam logic [ADDR_WIDTH:0]   COUNT      = (ADDR_WIDTH+1)'(PARTICLE_COUNT);
  localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_ONE = FRAME_CNT_WIDTH'(1);

  sched_state_t        state, state_next;
  logic [GUARD_W-1:0]  guard;
  logic                issue_start;
  logic                last_accepted;
  logic                in_issue, in_drain;

  assign in_issue = (state == ST_DEN_ISSUE) || (state == ST_UPD_ISSUE);
  assign in_drain = (state == ST_DEN_DRAIN) || (state == ST_UPD_DRAIN);

  index_issuer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_issuer (
    .clk_in       (clk_in),
    .rst          (rst),
    .start        (issue_start),
    .count        (COUNT),
    .idx          (idx_out),
    .valid        (idx_valid_out),
    .ready        (idx_ready_in),
    .last_accepted(last_accepted)
  );

  // Next-state logic and the issuer start pulse.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    state_next  = state;
    issue_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_in || step_in) begin
          state_next  = ST_DEN_ISSUE;
          issue_start = 1'b1;
        end
      end
      ST_DEN_ISSUE: if (last_accepted) state_next = ST_DEN_DRAIN;
      ST_DEN_DRAIN: begin
        if (guard == '0 && !pipe_busy_in) begin
          state_next  = ST_UPD_ISSUE;
          issue_start = 1'b1;
        end
      end
      ST_UPD_ISSUE: if (last_accepted) state_next = ST_UPD_DRAIN;
      ST_UPD_DRAIN: if (guard == '0 && !pipe_busy_in) state_next = ST_SWAP_START;
      ST_SWAP_START: state_next = ST_SWAP_ARM;
      // The buffer still shows its old done flag here; never sample it.
      ST_SWAP_ARM:   state_next = ST_SWAP_WAIT;
      ST_SWAP_WAIT:  if (swap_done_in) state_next = ST_DONE;
      ST_DONE:       state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // State register with outputs registered from the next state, so each
  // output lines up with the state it describes.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state             <= ST_IDLE;
      phase_out         <= PH_IDLE;
      busy_out          <= 1'b0;
      swap_activate_out <= 1'b0;
      frame_done_out    <= 1'b0;
      frame_count_out   <= '0;
    end else begin
      state             <= state_next;
      phase_out         <= phase_of(state_next);
      busy_out          <= (state_next != ST_IDLE);
      swap_activate_out <= (state_next == ST_SWAP_START);
      frame_done_out    <= (state_next == ST_DONE);
      if (state_next == ST_DONE) begin
        frame_count_out <= frame_count_out + FRAME_ONE;
      end
    end
  end

  // Drain guard: loaded on the last accept, counted down while draining.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      guard <= '0;
    end else if (in_issue && last_accepted) begin
      guard <= GUARD_LOAD;
    end else if (in_drain && guard != '0) begin
      guard <= guard - 1'b1;
    end
  end

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Self-checking bench for sim_step_scheduler. A negedge process plays the
// pipeline (random or constant ready, scripted busy) and the update buffer
// stub, and logs accepted indices and event cycles; the test tasks compare
// those logs against expectations derived from the frame rules.
module tb_sim_step_scheduler;

  localparam int AW   = 7;
  localparam int PC   = 128;
  localparam int DG   = 2;
  localparam int FW   = 16;
  localparam int HIST = 16384;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          run_in = 1'b0;
  logic          step_in = 1'b0;
  logic          idx_ready_in = 1'b0;
  logic          pipe_busy_in = 1'b0;
  logic          swap_done_in = 1'b1;
  logic [AW-1:0] idx_out;
  logic          idx_valid_out;
  logic [1:0]    phase_out;
  logic          swap_activate_out;
  logic          frame_done_out;
  logic [FW-1:0] frame_count_out;
  logic          busy_out;

  always #5 clk_in = ~clk_in;

  sim_step_scheduler #(
    .ADDR_WIDTH(AW), .PARTICLE_COUNT(PC), .DRAIN_GUARD(DG), .FRAME_CNT_WIDTH(FW)
  ) dut (
    .clk_in(clk_in), .rst(rst), .run_in(run_in), .step_in(step_in),
    .idx_out(idx_out), .idx_valid_out(idx_valid_out), .idx_ready_in(idx_ready_in),
    .pipe_busy_in(pipe_busy_in), .phase_out(phase_out),
    .swap_activate_out(swap_activate_out), .swap_done_in(swap_done_in),
    .frame_done_out(frame_done_out), .frame_count_out(frame_count_out),
    .busy_out(busy_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_frames = 0;

  typedef struct {
    int phase;
    int idx;
    int at;
  } acc_t;

  acc_t acc_q[$];
  int   done_q[$];
  int   start_q[$];
  int   upd_start_q[$];
  int   act_cnt = 0, act_cyc = -1, stall_viol = 0, oob_viol = 0;
  logic [1:0] phase_hist [0:HIST-1];
  logic       busy_hist  [0:HIST-1];

  int ready_mode = 0;    // 0: always ready, 1: ~50% random
  int busy_hold = 0;     // busy cycles after the last DENSITY accept
  int busy_cnt = 0, busy_fall_cyc = -1;
  int stub_lat = 3, stub_drop = 0, stub_hold = 0, stub_rise_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_idx = '0;
  logic [1:0]    prev_phase = 2'd0;

  always @(posedge clk_in) cyc++;

  // Pipeline / buffer model and monitor. Runs on the falling edge: outputs
  // seen here are those after posedge `cyc`, and an accept logged here takes
  // effect at posedge cyc+1.
  always @(negedge clk_in) begin : engine
    logic rdy;
    acc_t a;
    if (cyc < HIST) begin
      phase_hist[cyc] = phase_out;
      busy_hist[cyc]  = busy_out;
    end
    if (!rst) begin
      if (prev_stall && (!idx_valid_out || idx_out !== prev_idx)) stall_viol++;
      if (idx_valid_out && int'(idx_out) >= PC) oob_viol++;
      if (swap_activate_out) begin act_cnt++; act_cyc = cyc; end
      if (frame_done_out) done_q.push_back(cyc);
      if (phase_out == 2'd1 && prev_phase == 2'd0) start_q.push_back(cyc);
      if (phase_out == 2'd2 && prev_phase == 2'd1) upd_start_q.push_back(cyc);
    end
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin pipe_busy_in = 1'b0; busy_fall_cyc = cyc; end
    end
    rdy = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
    idx_ready_in = rdy;
    if (!rst && idx_valid_out && rdy) begin
      a.phase = int'(phase_out);
      a.idx   = int'(idx_out);
      a.at    = cyc + 1;
      acc_q.push_back(a);
      if (phase_out == 2'd1 && int'(idx_out) == PC-1 && busy_hold > 0) begin
        pipe_busy_in = 1'b1;
        busy_cnt     = busy_hold;
      end
    end
    prev_stall = idx_valid_out && !rdy;
    prev_idx   = idx_out;
    prev_phase = phase_out;
    // Update buffer: drops done one cycle after sampling activate, raises
    // it again stub_lat cycles later.
    if (rst) begin
      swap_done_in = 1'b1; stub_drop = 0; stub_hold = 0;
    end else if (swap_activate_out) begin
      stub_drop = 2;
    end else if (stub_drop > 0) begin
      stub_drop--;
      if (stub_drop == 0) begin swap_done_in = 1'b0; stub_hold = stub_lat; end
    end else if (stub_hold > 0) begin
      stub_hold--;
      if (stub_hold == 0) begin swap_done_in = 1'b1; stub_rise_cyc = cyc; end
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic clear_mon();
    acc_q.delete(); done_q.delete(); start_q.delete(); upd_start_q.delete();
    act_cnt = 0; act_cyc = -1; stall_viol = 0; oob_viol = 0;
    stub_rise_cyc = -1; busy_fall_cyc = -1;
  endtask

  task automatic pulse_step(output int at);
    tick();
    step_in = 1'b1;
    at = cyc;
    tick();
    step_in = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int b = 0;
    while (done_q.size() < n && b < budget) begin tick(); b++; end
    checks++;
    if (done_q.size() < n) begin
      errors++;
      $display("FAIL %s frame timeout: got %0d frames, want %0d", tag, done_q.size(), n);
    end
  endtask

  // Scoreboard: each frame accepts 0..PC-1 in DENSITY then 0..PC-1 in UPDATE.
  task automatic score_passes(input int frames, input string tag);
    int n_exp = frames * 2 * PC;
    int n = (acc_q.size() < n_exp) ? acc_q.size() : n_exp;
    checks++;
    if (acc_q.size() != n_exp) begin
      errors++;
      $display("FAIL %s accept count: got %0d want %0d", tag, acc_q.size(), n_exp);
    end
    for (int k = 0; k < n; k++) begin
      int ep = ((k / PC) % 2) + 1;
      int ei = k % PC;
      checks++;
      if (acc_q[k].phase !== ep || acc_q[k].idx !== ei) begin
        errors++;
        $display("FAIL %s accept[%0d]: got phase %0d idx %0d want phase %0d idx %0d",
                 tag, k, acc_q[k].phase, acc_q[k].idx, ep, ei);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (idx_out !== '0 || idx_valid_out !== 1'b0 || phase_out !== 2'd0 ||
        swap_activate_out !== 1'b0 || frame_done_out !== 1'b0 ||
        busy_out !== 1'b0 || frame_count_out !== '0) begin
      errors++;
      $display("FAIL %s outputs: idx %0d valid %0b phase %0d act %0b done %0b busy %0b count %0d, want all 0",
               tag, idx_out, idx_valid_out, phase_out, swap_activate_out,
               frame_done_out, busy_out, frame_count_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run_in = 1'b0; step_in = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    exp_frames = 0;
    repeat (2) tick();
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset idle hold: busy %0b want 0", busy_out);
    end
  endtask

  task automatic test_single_step();
    int st, p0, pu;
    clear_mon(); ready_mode = 0; busy_hold = 0; stub_lat = 3;
    pulse_step(st);
    wait_frames(1, 2000, "single_step");
    repeat (3) tick();
    exp_frames++;
    score_passes(1, "single_step");
    checks++;
    if (act_cnt !== 1) begin errors++; $display("FAIL single_step activates: got %0d want 1", act_cnt); end
    checks++;
    if (done_q.size() !== 1) begin errors++; $display("FAIL single_step frame_done: got %0d want 1", done_q.size()); end
    checks++;
    if (frame_count_out !== FW'(exp_frames)) begin
      errors++; $display("FAIL single_step frame_count: got %0d want %0d", frame_count_out, exp_frames);
    end
    checks++;
    if (phase_out !== 2'd0 || busy_out !== 1'b0) begin
      errors++; $display("FAIL single_step back to idle: phase %0d busy %0b want 0 0", phase_out, busy_out);
    end
    if (acc_q.size() == 2*PC && done_q.size() == 1) begin
      p0 = acc_q[PC-1].at;
      pu = acc_q[2*PC-1].at;
      checks++;
      if (acc_q[0].at !== st + 2) begin
        errors++; $display("FAIL single_step first accept cycle: got %0d want %0d", acc_q[0].at, st + 2);
      end
      checks++;
      if (acc_q[PC].at !== p0 + DG + 2) begin
        errors++; $display("FAIL single_step guard drain: got %0d want %0d", acc_q[PC].at, p0 + DG + 2);
      end
      checks++;
      if (act_cyc !== pu + DG + 1) begin
        errors++; $display("FAIL single_step activate cycle: got %0d want %0d", act_cyc, pu + DG + 1);
      end
      checks++;
      if (done_q[0] !== stub_rise_cyc + 1) begin
        errors++; $display("FAIL single_step done cycle: got %0d want %0d", done_q[0], stub_rise_cyc + 1);
      end
    end
  endtask

  task automatic test_random_stall();
    int st;
    clear_mon(); ready_mode = 1;
    pulse_step(st);
    repeat (50) tick();
    pulse_step(st);  // mid-frame step must be ignored
    wait_frames(1, 4000, "random_stall");
    repeat (300) tick();
    exp_frames++;
    ready_mode = 0;
    checks++;
    if (stall_viol !== 0) begin errors++; $display("FAIL random_stall idx stability: got %0d violations want 0", stall_viol); end
    checks++;
    if (oob_viol !== 0) begin errors++; $display("FAIL random_stall index range: got %0d violations want 0", oob_viol); end
    checks++;
    if (done_q.size() !== 1) begin errors++; $display("FAIL random_stall frames: got %0d want 1", done_q.size()); end
    score_passes(1, "random_stall");
    checks++;
    if (frame_count_out !== FW'(exp_frames)) begin
      errors++; $display("FAIL random_stall frame_count: got %0d want %0d", frame_count_out, exp_frames);
    end
  endtask

  task automatic test_drain_busy();
    int st, p0, e;
    clear_mon(); ready_mode = 0; busy_hold = 10;
    pulse_step(st);
    wait_frames(1, 2000, "drain_busy");
    repeat (3) tick();
    exp_frames++;
    busy_hold = 0;
    score_passes(1, "drain_busy");
    checks++;
    if (upd_start_q.size() !== 1 || acc_q.size() != 2*PC) begin
      errors++; $display("FAIL drain_busy update start count: got %0d want 1", upd_start_q.size());
    end else begin
      p0 = acc_q[PC-1].at;
      e  = p0 + DG + 1;
      if (busy_fall_cyc + 1 > e) e = busy_fall_cyc + 1;
      checks++;
      if (upd_start_q[0] !== e) begin
        errors++; $display("FAIL drain_busy update start: got cycle %0d want %0d", upd_start_q[0], e);
      end
      checks++;
      if (acc_q[PC].at !== e + 1) begin
        errors++; $display("FAIL drain_busy first update accept: got %0d want %0d", acc_q[PC].at, e + 1);
      end
      for (int c = p0; c < e; c++) begin
        checks++;
        if (phase_hist[c] !== 2'd1) begin
          errors++; $display("FAIL drain_busy phase at cycle %0d: got %0d want 1", c, phase_hist[c]);
        end
      end
    end
  endtask

  task automatic test_swap_latency();
    int st;
    clear_mon(); ready_mode = 0; stub_lat = 130;
    pulse_step(st);
    wait_frames(1, 3000, "swap_latency");
    repeat (3) tick();
    exp_frames++;
    stub_lat = 3;
    checks++;
    if (act_cnt !== 1) begin errors++; $display("FAIL swap_latency activates: got %0d want 1", act_cnt); end
    if (done_q.size() == 1 && act_cyc >= 0) begin
      checks++;
      if (done_q[0] !== stub_rise_cyc + 1) begin
        errors++; $display("FAIL swap_latency done cycle: got %0d want %0d", done_q[0], stub_rise_cyc + 1);
      end
      for (int c = act_cyc; c < done_q[0]; c++) begin
        checks++;
        if (phase_hist[c] !== 2'd3) begin
          errors++; $display("FAIL swap_latency phase at cycle %0d: got %0d want 3", c, phase_hist[c]);
        end
      end
      checks++;
      if (phase_hist[done_q[0]] !== 2'd0 || busy_hist[done_q[0]] !== 1'b1) begin
        errors++; $display("FAIL swap_latency done-cycle phase/busy: got %0d/%0b want 0/1",
                           phase_hist[done_q[0]], busy_hist[done_q[0]]);
      end
    end
    checks++;
    if (frame_count_out !== FW'(exp_frames)) begin
      errors++; $display("FAIL swap_latency frame_count: got %0d want %0d", frame_count_out, exp_frames);
    end
  endtask

  task automatic test_run_frames();
    int b = 0;
    clear_mon(); ready_mode = 1;
    tick();
    run_in = 1'b1;
    wait_frames(3, 6000, "run_frames");
    while (acc_q.size() < 3*2*PC + PC + 20 && b < 3000) begin tick(); b++; end
    checks++;
    if (acc_q.size() < 3*2*PC + PC + 20) begin
      errors++; $display("FAIL run_frames frame 4 update timeout: got %0d accepts", acc_q.size());
    end
    run_in = 1'b0;
    wait_frames(4, 4000, "run_frames");
    repeat (400) tick();
    exp_frames += 4;
    ready_mode = 0;
    checks++;
    if (done_q.size() !== 4) begin errors++; $display("FAIL run_frames frame count: got %0d want 4", done_q.size()); end
    checks++;
    if (start_q.size() !== 4) begin errors++; $display("FAIL run_frames starts: got %0d want 4", start_q.size()); end
    if (done_q.size() == 4 && start_q.size() == 4) begin
      for (int f = 0; f < 3; f++) begin
        checks++;
        if (start_q[f+1] !== done_q[f] + 2 || phase_hist[done_q[f] + 1] !== 2'd0) begin
          errors++; $display("FAIL run_frames gap after frame %0d: start %0d want %0d", f + 1,
                             start_q[f+1], done_q[f] + 2);
        end
      end
    end
    score_passes(4, "run_frames");
    checks++;
    if (stall_viol !== 0) begin errors++; $display("FAIL run_frames idx stability: got %0d want 0", stall_viol); end
    checks++;
    if (frame_count_out !== FW'(exp_frames) || busy_out !== 1'b0) begin
      errors++; $display("FAIL run_frames final: count %0d busy %0b want %0d 0", frame_count_out, busy_out, exp_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    int st, b = 0;
    clear_mon(); ready_mode = 1;
    pulse_step(st);
    while (!(phase_out == 2'd2 && idx_valid_out && idx_out == AW'(40)) && b < 3000) begin tick(); b++; end
    checks++;
    if (!(phase_out == 2'd2 && idx_valid_out && idx_out == AW'(40))) begin
      errors++; $display("FAIL reset_mid_frame reach idx 40: phase %0d idx %0d", phase_out, idx_out);
    end
    rst = 1'b1;
    tick();
    check_idle_outputs("reset_mid_frame");
    rst = 1'b0;
    exp_frames = 0;
    clear_mon();
    repeat (200) tick();
    checks++;
    if (act_cnt !== 0 || done_q.size() !== 0 || busy_out !== 1'b0) begin
      errors++; $display("FAIL reset_mid_frame aborted: act %0d done %0d busy %0b want 0 0 0",
                         act_cnt, done_q.size(), busy_out);
    end
    ready_mode = 0;
    pulse_step(st);
    wait_frames(1, 2000, "reset_restart");
    repeat (3) tick();
    exp_frames++;
    checks++;
    if (acc_q.size() == 0 || acc_q[0].phase !== 1 || acc_q[0].idx !== 0 || acc_q[0].at !== st + 2) begin
      errors++; $display("FAIL reset_restart first accept: got %0d entries, want DENSITY idx 0 at %0d",
                         acc_q.size(), st + 2);
    end
    score_passes(1, "reset_restart");
    checks++;
    if (frame_count_out !== FW'(exp_frames)) begin
      errors++; $display("FAIL reset_restart frame_count: got %0d want %0d", frame_count_out, exp_frames);
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_random_stall();
    test_drain_busy();
    test_swap_latency();
    test_run_frames();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
